// File: rtl/data_sram_responder.sv
// data_sram_responder: 1024x32 single-port data SRAM with a 4-entry FIFO write buffer.
// Writes are posted into the buffer and drained into the array on cycles without an
// accepted read. Define DSRAM_FWD_EN to merge buffered bytes into reads instead of
// stalling reads that hit a pending write.
module data_sram_responder (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_stall,
  output logic [2:0]  wbuf_count
);
  localparam int unsigned Depth = 4;

  logic [31:0] mem [1024];

  logic [9:0]  buf_idx_q  [Depth];
  logic [3:0]  buf_wen_q  [Depth];
  logic [31:0] buf_data_q [Depth];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] rdata_q;

  logic [9:0]       req_idx;
  logic             is_wr, is_rd, full;
  logic             acc_rd, acc_wr, drain;
  logic [Depth-1:0] valid;
  logic [31:0]      rd_word;

  // Address bits outside the word index carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{data_sram_addr[31:12], data_sram_addr[1:0]};

  assign req_idx = data_sram_addr[11:2];
  assign is_wr   = data_sram_en & (data_sram_wen != 4'b0000);
  assign is_rd   = data_sram_en & (data_sram_wen == 4'b0000);
  assign full    = (count_q == 3'd4);

  // Slot s is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [1:0] age;
    valid = '0;
    age   = '0;
    for (int s = 0; s < Depth; s++) begin
      age      = 2'(s) - rd_ptr_q;
      valid[s] = ({1'b0, age} < count_q);
    end
  end

`ifdef DSRAM_FWD_EN
  // Read word: array contents overlaid with matching buffered bytes, oldest first.
  always_comb begin
    logic [1:0] slot;
    rd_word = mem[req_idx];
    slot    = '0;
    for (int i = 0; i < Depth; i++) begin
      slot = rd_ptr_q + 2'(i);
      if (valid[slot] && (buf_idx_q[slot] == req_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (buf_wen_q[slot][b]) rd_word[8*b +: 8] = buf_data_q[slot][8*b +: 8];
        end
      end
    end
  end

  assign data_sram_stall = resetn & is_wr & full;
`else
  logic idx_match;

  assign rd_word = mem[req_idx];

  // A read hitting any pending write must wait until that write has drained.
  always_comb begin
    idx_match = 1'b0;
    for (int s = 0; s < Depth; s++) begin
      if (valid[s] && (buf_idx_q[s] == req_idx)) idx_match = 1'b1;
    end
  end

  assign data_sram_stall = resetn & ((is_wr & full) | (is_rd & idx_match));
`endif

  assign acc_rd = resetn & is_rd & ~data_sram_stall;
  assign acc_wr = resetn & is_wr & ~data_sram_stall;
  // An accepted read owns the array port; otherwise retire the oldest entry.
  assign drain  = resetn & ~acc_rd & (count_q != 3'd0);

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, acc_wr};
    rd_ptr_d = rd_ptr_q + {1'b0, drain};
    count_d  = count_q + {2'b00, acc_wr} - {2'b00, drain};
  end

  // Buffer control state and registered read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (acc_rd) rdata_q <= rd_word;
    end
  end

  // Buffer entry payloads; liveness comes from the occupancy, so no reset is needed.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      buf_idx_q[wr_ptr_q]  <= req_idx;
      buf_wen_q[wr_ptr_q]  <= data_sram_wen;
      buf_data_q[wr_ptr_q] <= data_sram_wdata;
    end
  end

  // Array write port: commit the oldest buffered write, enabled lanes only.
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_wen_q[rd_ptr_q][b]) begin
          mem[buf_idx_q[rd_ptr_q]][8*b +: 8] <= buf_data_q[rd_ptr_q][8*b +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign wbuf_count      = count_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a queue-based reference model predicts
// stall, occupancy and read data; a separate monitor checks read data as it appears.
`timescale 1ns/1ps
module tb_data_sram_responder;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic [2:0]  wbuf_count;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .data_sram_stall (stall),
    .wbuf_count      (wbuf_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  idx;
    logic [3:0]  wen;
    logic [31:0] data;
  } wr_t;

  logic [31:0] model_mem [1024];
  wr_t         pend[$];    // posted writes, oldest first
  logic [31:0] exp_q[$];   // expected data of accepted reads, in order

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // What a read of idx returns: array word with pending bytes overlaid in age order.
  function automatic logic [31:0] merge_read(input logic [9:0] idx);
    logic [31:0] w;
    w = model_mem[idx];
    foreach (pend[i]) begin
      if (pend[i].idx == idx) begin
        for (int b = 0; b < 4; b++) if (pend[i].wen[b]) w[8*b +: 8] = pend[i].data[8*b +: 8];
      end
    end
    return w;
  endfunction

  // One clock: drive inputs, check stall/occupancy, advance the model across the next edge.
  task automatic cycle(input logic rst_n, input logic req_en, input logic [3:0] req_wen,
                       input logic [31:0] req_addr, input logic [31:0] req_wdata,
                       output logic accepted);
    logic [9:0] idx;
    logic       is_wr, is_rd, match, exp_stall, acc_rd;
    @(posedge clk);
    #1;
    resetn = rst_n;
    en     = req_en;
    wen    = req_wen;
    addr   = req_addr;
    wdata  = req_wdata;
    @(negedge clk);
    idx      = req_addr[11:2];
    accepted = 1'b0;
    if (!rst_n) begin
      check("stall_in_reset", {31'b0, stall}, 32'd0);
      pend.delete();
    end else begin
      is_wr = req_en && (req_wen != 4'h0);
      is_rd = req_en && (req_wen == 4'h0);
      match = 1'b0;
      foreach (pend[i]) if (pend[i].idx == idx) match = 1'b1;
`ifdef DSRAM_FWD_EN
      exp_stall = is_wr && (pend.size() == 4);
`else
      exp_stall = (is_wr && (pend.size() == 4)) || (is_rd && match);
`endif
      check("wbuf_count", 32'(wbuf_count), 32'(pend.size()));
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      acc_rd = is_rd && !exp_stall;
      if (acc_rd) exp_q.push_back(merge_read(idx));
      if (!acc_rd && (pend.size() > 0)) begin
        wr_t e;
        e = pend.pop_front();
        for (int b = 0; b < 4; b++) if (e.wen[b]) model_mem[e.idx][8*b +: 8] = e.data[8*b +: 8];
      end
      if (is_wr && !exp_stall) pend.push_back('{idx, req_wen, req_wdata});
      accepted = req_en && !exp_stall;
    end
  endtask

  // Hold a request until accepted; n returns the number of cycles it was presented.
  task automatic request(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                         output int n);
    logic acc;
    n = 0;
    do begin
      cycle(1'b1, 1'b1, w, a, d, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL request_timeout: not accepted after %0d cycles", n);
    end
  endtask

  task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int n;
    request(w, a, d, n);
  endtask

  // Idle cycles drive junk on the request lines with en low.
  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b1, 1'b0, 4'($urandom), $urandom, $urandom, acc);
  endtask

  // Reset cycles carry a live-looking write that must be ignored.
  task automatic do_reset(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 1'b1, 4'hF, $urandom, $urandom, acc);
  endtask

  // Monitor: a read accepted at an edge shows its data by the following negedge;
  // otherwise the output must hold its last value.
  logic        mon_acc = 1'b0;
  logic        mon_rst = 1'b0;
  logic        mon_live = 1'b0;
  logic [31:0] held = 32'h0;

  always @(posedge clk) begin
    mon_rst <= !resetn;
    mon_acc <= resetn && en && (wen == 4'h0) && !stall;
  end

  always @(negedge clk) begin
    if (mon_rst) begin
      held     = 32'h0;
      mon_live = 1'b1;
      check("rdata_reset", rdata, 32'h0);
    end else if (mon_live) begin
      if (mon_acc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_unexpected: got %h with no read expected", rdata);
        end else begin
          held = exp_q.pop_front();
          check("rdata_read", rdata, held);
        end
      end else begin
        check("rdata_hold", rdata, held);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: bench did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [31:0] a;
    logic [31:0] old15;
    int          r;

    do_reset(2);
    check("count_after_reset", 32'(wbuf_count), 32'd0);

    // Preload every word the bench will ever read (indices 4..19).
    for (int i = 4; i < 20; i++) req(4'hF, 32'(i) << 2, $urandom);
    idle(3);

    // Basic write then read back.
    req(4'h0, 32'h10, 32'h0);
    idle(1);
    req(4'hF, 32'h10, 32'hAABBCCDD);
    idle(2);
    req(4'h0, 32'h10, 32'h0);
    idle(1);
    check("s1_rdata", rdata, 32'hAABBCCDD);
    check("s1_count", 32'(wbuf_count), 32'd0);

    // Back-to-back writes, then read them all back.
    req(4'hF, 32'h14, 32'h05050505);
    req(4'hF, 32'h18, 32'h06060606);
    req(4'hF, 32'h1C, 32'h07070707);
    req(4'hF, 32'h24, 32'h09090909);
    req(4'hF, 32'h2C, 32'h0B0B0B0B);
    idle(2);
    req(4'h0, 32'h2C, 32'h0);
    idle(1);
    check("s2_rdata", rdata, 32'h0B0B0B0B);
    req(4'h0, 32'h14, 32'h0);
    req(4'h0, 32'h18, 32'h0);
    req(4'h0, 32'h1C, 32'h0);
    req(4'h0, 32'h24, 32'h0);
    idle(1);

    // Partial write followed immediately by a read of the same word.
    req(4'hF, 32'h20, 32'h11223344);
    idle(2);
    req(4'b0010, 32'h20, 32'h0000EE00);
    request(4'h0, 32'h20, 32'h0, n);
`ifdef DSRAM_FWD_EN
    check("s3_read_cycles", 32'(n), 32'd1);
`else
    check("s3_read_cycles", 32'(n), 32'd2);
`endif
    idle(1);
    check("s3_rdata", rdata, 32'h1122EE44);

    // Two writes to one word, newest byte wins.
    req(4'hF, 32'h30, 32'h01010101);
    req(4'b0001, 32'h30, 32'h000000FF);
    req(4'h0, 32'h30, 32'h0);
    idle(1);
    check("s4_rdata", rdata, 32'h010101FF);

    // Reset with writes in flight discards what is still buffered.
    idle(2);
    old15 = model_mem[15];
    req(4'hF, 32'h34, 32'hD1D1D1D1);
    req(4'hF, 32'h38, 32'hD2D2D2D2);
    req(4'hF, 32'h3C, 32'hD3D3D3D3);
    do_reset(1);
    idle(1);
    check("s5_count", 32'(wbuf_count), 32'd0);
    check("s5_rdata", rdata, 32'h0);
    req(4'h0, 32'h3C, 32'h0);
    idle(1);
    check("s5_discarded", rdata, old15);
    req(4'h0, 32'h34, 32'h0);
    req(4'h0, 32'h38, 32'h0);

    // Reads own the port: a pending write waits for an idle cycle.
    req(4'hF, 32'h44, 32'h44444444);
    repeat (4) req(4'h0, 32'h40, 32'h0);
    idle(1);
    check("s6_count_held", 32'(wbuf_count), 32'd1);
    idle(1);
    check("s6_count_drained", 32'(wbuf_count), 32'd0);

    // Randomized traffic over the preloaded words, with ignored upper address bits.
    for (int k = 0; k < 400; k++) begin
      a       = $urandom;
      a[11:2] = 10'(4 + $urandom_range(0, 15));
      r       = $urandom_range(0, 9);
      if (r < 4) req(4'($urandom_range(1, 15)), a, $urandom);
      else if (r < 8) req(4'h0, a, 32'h0);
      else if ($urandom_range(0, 19) == 0) do_reset(1);
      else idle($urandom_range(1, 2));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
